// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding SRAM-like fetch, flush cancels in-flight data.
// Optional feature macro IF_ADEF_EN: misaligned PCs raise a fetch exception instead of fetching.
module if_stage #(
  parameter logic [31:0] INST_NOP = 32'h03400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pre_valid,
  input  logic [31:0] pre_pc,
  output logic        if_allowin,
  input  logic        flush,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        id_allowin,
  output logic        if_to_id_valid,
  output logic [31:0] if_to_id_pc,
  output logic [31:0] if_to_id_inst,
  output logic        if_to_id_ex
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] inst_q, inst_d;
  logic        cancel_q, cancel_d;
  logic        pend_q, pend_d;
  logic        ex_q, ex_d;

  logic        accept_s;
  logic        launch_s;
  logic        drain_s;
  logic        misalign_s;
  logic        pend_misalign_s;

`ifdef IF_ADEF_EN
  assign misalign_s      = (pre_pc[1:0] != 2'b00);
  assign pend_misalign_s = (pc_q[1:0] != 2'b00);
`else
  assign misalign_s      = 1'b0;
  assign pend_misalign_s = 1'b0;
`endif

  assign if_allowin = flush | (state_q == S_IDLE) | ((state_q == S_HOLD) & id_allowin);
  assign accept_s   = pre_valid & if_allowin;

  // Next-state logic; flush overrides everything, launch_s starts a fetch of pre_pc.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inst_d     = inst_q;
    cancel_d   = cancel_q;
    pend_d     = pend_q;
    ex_d       = ex_q;
    launch_s   = 1'b0;
    drain_s    = 1'b0;

    if (flush) begin
      // A request already issued (or being issued) still owes one response.
      drain_s  = (state_q == S_REQ) || ((state_q == S_WAIT) && !inst_sram_data_ok);
      cancel_d = drain_s;
      ex_d     = 1'b0;
      case (state_q)
        S_REQ:   state_d = inst_sram_addr_ok ? S_WAIT : S_REQ;
        S_WAIT:  state_d = inst_sram_data_ok ? S_IDLE : S_WAIT;
        default: state_d = S_IDLE;
      endcase
      if (accept_s) begin
        pc_d = pre_pc;
        if (drain_s) begin
          pend_d = 1'b1;
        end else begin
          pend_d   = 1'b0;
          launch_s = 1'b1;
        end
      end else begin
        pend_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            launch_s = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_REQ: begin
          if (inst_sram_addr_ok) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (inst_sram_data_ok && !cancel_q) begin
            state_d = S_HOLD;
            inst_d  = inst_sram_rdata;
            ex_d    = 1'b0;
          end else if (inst_sram_data_ok) begin
            cancel_d = 1'b0;
            pend_d   = 1'b0;
            if (!pend_q) begin
              state_d = S_IDLE;
            end else if (pend_misalign_s) begin
              state_d = S_HOLD;
              inst_d  = INST_NOP;
              ex_d    = 1'b1;
            end else begin
              state_d    = S_REQ;
              req_addr_d = pc_q;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          if (id_allowin) begin
            ex_d = 1'b0;
            if (accept_s) begin
              launch_s = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_HOLD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (launch_s) begin
      pc_d = pre_pc;
      if (misalign_s) begin
        state_d = S_HOLD;
        inst_d  = INST_NOP;
        ex_d    = 1'b1;
      end else begin
        state_d    = S_REQ;
        req_addr_d = pre_pc;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= 32'h0000_0000;
      req_addr_q <= 32'h0000_0000;
      inst_q     <= 32'h0000_0000;
      cancel_q   <= 1'b0;
      pend_q     <= 1'b0;
      ex_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inst_q     <= inst_d;
      cancel_q   <= cancel_d;
      pend_q     <= pend_d;
      ex_q       <= ex_d;
    end
  end

  assign inst_sram_req  = (state_q == S_REQ);
  assign inst_sram_wr   = 1'b0;
  assign inst_sram_size = 2'b10;
  assign inst_sram_addr = req_addr_q;
  // A flush in the same cycle hides held content from ID.
  assign if_to_id_valid = (state_q == S_HOLD) & ~flush;
  assign if_to_id_pc    = pc_q;
  assign if_to_id_inst  = inst_q;
  assign if_to_id_ex    = ex_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic against a
// transaction-level scoreboard (accepted PCs in order, flush discards older ones).
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        pre_valid;
  logic [31:0] pre_pc;
  logic        if_allowin;
  logic        flush;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [31:0] if_to_id_pc;
  logic [31:0] if_to_id_inst;
  logic        if_to_id_ex;

  if_stage dut (
    .clk(clk), .reset(reset), .pre_valid(pre_valid), .pre_pc(pre_pc), .if_allowin(if_allowin),
    .flush(flush), .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .id_allowin(id_allowin), .if_to_id_valid(if_to_id_valid),
    .if_to_id_pc(if_to_id_pc), .if_to_id_inst(if_to_id_inst), .if_to_id_ex(if_to_id_ex)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Stimulus knobs applied by step()
  logic        pv, fl, ida, aok;
  logic [31:0] ppc;
  int          dly;
  logic        acc_r;

  // Memory slave state
  logic        out_v;
  logic [31:0] out_addr;
  int          out_cnt;
  logic        prev_pending;
  logic [31:0] prev_addr;

  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h1c00_0000) return 32'h0280_0421;
    return {a[15:0] ^ 16'h9bdf, ~a[31:16]};
  endfunction

  function automatic logic is_mis(input logic [31:0] a);
`ifdef IF_ADEF_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0 & a[0];
`endif
  endfunction

  // One clock cycle: drive, settle, update the reference model, advance to posedge+1.
  task automatic step();
    logic fire, hs;
    logic [31:0] e;
    pre_valid         = pv;
    pre_pc            = ppc;
    flush             = fl;
    id_allowin        = ida;
    inst_sram_addr_ok = aok;
    inst_sram_data_ok = out_v && (out_cnt == 0);
    inst_sram_rdata   = out_v ? mem(out_addr) : 32'h0000_0000;
    #1;
    acc_r = pre_valid & if_allowin;
    fire  = if_to_id_valid & id_allowin;
    hs    = inst_sram_req & inst_sram_addr_ok;
    if (flush) check_val("valid_during_flush", 32'(if_to_id_valid), 32'd0);
    if (if_to_id_valid && !id_allowin && !flush) check_val("stall_allowin", 32'(if_allowin), 32'd0);
    if (fire) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_fire", 32'(fire), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("id_pc", if_to_id_pc, e);
        check_val("id_inst", if_to_id_inst, is_mis(e) ? 32'h0340_0000 : mem(e));
        check_val("id_ex", 32'(if_to_id_ex), 32'(is_mis(e)));
      end
    end
    if (flush) exp_q.delete();
    if (acc_r) exp_q.push_back(pre_pc);
    if (prev_pending) begin
      check_val("req_held", 32'(inst_sram_req), 32'd1);
      check_val("addr_stable", inst_sram_addr, prev_addr);
    end
    prev_pending = inst_sram_req & ~inst_sram_addr_ok;
    prev_addr    = inst_sram_addr;
    if (inst_sram_data_ok) out_v = 1'b0;
    if (hs) begin
      check_val("one_outstanding", 32'(out_v), 32'd0);
`ifdef IF_ADEF_EN
      check_val("adef_no_req", 32'(inst_sram_addr[1:0]), 32'd0);
`endif
      out_v    = 1'b1;
      out_addr = inst_sram_addr;
      out_cnt  = dly;
    end else if (out_v && out_cnt > 0) begin
      out_cnt--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    pv = 1'b0; fl = 1'b0; ida = 1'b1; aok = 1'b1; dly = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    logic seen_req, seen_valid, tmis;
    logic [31:0] cur_pc, tgt;
    reset = 1'b1; pre_valid = 1'b0; pre_pc = 32'h0; flush = 1'b0; id_allowin = 1'b1;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    pv = 1'b0; fl = 1'b0; ida = 1'b1; aok = 1'b0; ppc = 32'h0; dly = 0; acc_r = 1'b0;
    out_v = 1'b0; out_addr = 32'h0; out_cnt = 0; prev_pending = 1'b0; prev_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", 32'(if_to_id_valid), 32'd0);
    check_val("rst_req", 32'(inst_sram_req), 32'd0);
    check_val("rst_allowin", 32'(if_allowin), 32'd1);
    check_val("rst_ex", 32'(if_to_id_ex), 32'd0);
    check_val("rst_wr_size", {29'd0, inst_sram_wr, inst_sram_size}, 32'd2);
    check_val("rst_pc_inst", if_to_id_pc | if_to_id_inst | inst_sram_addr, 32'd0);
    reset = 1'b0;

    // Minimum latency: accept T, req T+1, data T+2, valid T+3
    pv = 1'b1; ppc = 32'h1c00_0000; aok = 1'b1; dly = 0; ida = 1'b1;
    step();
    pv = 1'b0;
    check_val("t1_req", 32'(inst_sram_req), 32'd1);
    check_val("t1_addr", inst_sram_addr, 32'h1c00_0000);
    step();
    check_val("t1_valid_early", 32'(if_to_id_valid), 32'd0);
    step();
    check_val("t1_valid", 32'(if_to_id_valid), 32'd1);
    check_val("t1_pc", if_to_id_pc, 32'h1c00_0000);
    check_val("t1_inst", if_to_id_inst, 32'h0280_0421);

    // addr_ok delayed three cycles
    pv = 1'b1; ppc = 32'h1c00_0004; aok = 1'b0;
    step();
    pv = 1'b0; ida = 1'b0; n = 0;
    for (int i = 0; i < 6; i++) begin
      if (inst_sram_req) begin
        n++;
        check_val("t2_addr", inst_sram_addr, 32'h1c00_0004);
      end
      aok = (i == 3);
      step();
    end
    check_val("t2_req_cycles", 32'(n), 32'd4);

    // ID stall in HOLD
    pv = 1'b1; ppc = 32'h1c00_0008;
    for (int i = 0; i < 5; i++) begin
      check_val("t3_valid", 32'(if_to_id_valid), 32'd1);
      check_val("t3_pc", if_to_id_pc, 32'h1c00_0004);
      check_val("t3_allowin", 32'(if_allowin), 32'd0);
      check_val("t3_no_req", 32'(inst_sram_req), 32'd0);
      step();
    end
    ida = 1'b1;
    step();

    // Flush while waiting for data: old response discarded
    pv = 1'b0; aok = 1'b1; dly = 2;
    step();
    fl = 1'b1; pv = 1'b1; ppc = 32'h1c00_0100;
    step();
    fl = 1'b0; pv = 1'b0; dly = 0; seen_req = 1'b0; seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (inst_sram_req && !seen_req) begin
        seen_req = 1'b1;
        check_val("t4_addr", inst_sram_addr, 32'h1c00_0100);
      end
      if (if_to_id_valid) seen_valid = 1'b1;
      step();
    end
    check_val("t4_seen", {30'd0, seen_req, seen_valid}, 32'd3);

    // Flush coinciding with data_ok
    pv = 1'b1; ppc = 32'h1c00_0200;
    step();
    pv = 1'b0;
    step();
    fl = 1'b1; pv = 1'b1; ppc = 32'h1c00_0300;
    step();
    check_val("t5_req", 32'(inst_sram_req), 32'd1);
    check_val("t5_addr", inst_sram_addr, 32'h1c00_0300);
    idle_steps(8);

    // Misaligned PC
    pv = 1'b1; ppc = 32'h1c00_0002;
    step();
    pv = 1'b0;
`ifdef IF_ADEF_EN
    check_val("t6_no_req", 32'(inst_sram_req), 32'd0);
    check_val("t6_valid", 32'(if_to_id_valid), 32'd1);
    check_val("t6_ex", 32'(if_to_id_ex), 32'd1);
    check_val("t6_inst", if_to_id_inst, 32'h0340_0000);
`else
    check_val("t6_req", 32'(inst_sram_req), 32'd1);
    check_val("t6_addr", inst_sram_addr, 32'h1c00_0002);
`endif
    idle_steps(8);

    // Randomized traffic
    cur_pc = 32'h1c00_1000;
    for (int c = 0; c < 3000; c++) begin
      fl  = ($urandom_range(0, 11) == 0);
      pv  = ($urandom_range(0, 3) != 0);
      ida = ($urandom_range(0, 3) != 0);
      aok = $urandom_range(0, 1) == 1;
      dly = $urandom_range(0, 3);
      tmis = ($urandom_range(0, 7) == 0);
      tgt = 32'h1c00_0000 | ($urandom & 32'h0000_fffc) | (tmis ? 32'(2'd2) : 32'd0);
      ppc = fl ? tgt : cur_pc;
      step();
      if (acc_r) cur_pc = ppc + 32'd4;
      else if (fl) cur_pc = tgt;
    end

    pv = 1'b0; fl = 1'b0; ida = 1'b1; aok = 1'b1; dly = 0;
    for (int i = 0; i < 60 && (exp_q.size() != 0 || out_v); i++) step();
    check_val("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
